uart_tx: RTL
============

# uart_tx

Byte-oriented UART transmitter: the transmit-side counterpart of the receive path in the traffic-light UART test design. It accepts bytes over a valid/ready handshake into a small FIFO and serialises each one on `tx` as 8N1 by default, with optional parity and 1 or 2 stop bits. Bytes are sent LSB first at a baud rate derived from the system clock. The block sits between the controller logic (status/echo reporting) and the board's UART TX pin.

## Interface
Parameters:
- `CLK_FREQ`, 12_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s. `CLKS_PER_BIT` = `CLK_FREQ/BAUD`, truncated; the default is 1250. `CLKS_PER_BIT` must be ≥ 2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: power of two, ≥ 2.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: the FIFO can accept a byte. Equals !full.
- `tx` out 1: serial line, idle high, registered.
- `busy` out 1: high while the FIFO is non-empty or a frame is in progress.

## Operation
- Push: a byte is written on any rising edge where `tx_valid && tx_ready`. The producer holds `tx_data` and `tx_valid` until that edge. Writes while full cannot happen, because `tx_ready` is low.
- FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, compute parity, reset the baud counter, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with the bit index at 0.
  - DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit, shifting right after each bit. After bit 7, go to PARITY if `PARITY`≠0, otherwise to STOP.
  - PARITY: `tx`=^data for even parity, or ~^data for odd parity, for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles. At the end:
    - if the FIFO is non-empty, pop the next byte and go straight to START with no idle cycle;
    - otherwise go to IDLE.
- Baud counter width is $clog2(`CLKS_PER_BIT`). It counts 0..`CLKS_PER_BIT`-1, resets on every bit boundary, and never wraps within a bit.
- FIFO occupancy count width is $clog2(`FIFO_DEPTH`)+1. Read and write pointers wrap modulo `FIFO_DEPTH`.
- Simultaneous push and pop in one cycle:
  - occupancy is unchanged;
  - the pushed byte is never lost or popped in the same cycle;
  - if the FIFO was full, no push occurs that cycle.
- Reset, at any time including mid-frame:
  - `tx`=1, FSM=IDLE, FIFO emptied, pointers and count cleared;
  - `tx_ready`=1 and `busy`=0;
  - the frame in progress is truncated and its byte is discarded.

## Timing
- Accept-to-line latency into an empty, idle block: the byte is pushed at edge N, the FSM pops it at edge N+1, and `tx` is low from edge N+1.
- Frame length is (1 + 8 + (`PARITY`≠0) + `STOP_BITS`) × `CLKS_PER_BIT` cycles. Every bit period is exactly `CLKS_PER_BIT` cycles, with no jitter.
- Back-to-back bytes: the next start bit begins on the cycle right after the last stop-bit cycle.
- `tx_ready` reflects registered occupancy. A pop in the current cycle does not raise `tx_ready` until the next cycle.
- `busy` rises on the edge after the first accepted push. It falls on the edge where the FSM returns to IDLE with the FIFO empty.
- Throughput: one byte per frame length. The FIFO absorbs bursts of up to `FIFO_DEPTH` bytes plus the one in the shift register.

## Structure
- Shared package `uart_pkg`, also used by the receiver:
  - parity constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - the FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - a `clks_per_bit(clk_freq, baud)` function.
- Sub-module `uart_tx_fifo`: a synchronous FIFO with registered count and full/empty flags. It is parameterised by width (8) and depth.
- The FSM, baud counter, bit index, and shift register live in `uart_tx`.

## Test plan
Benches use `CLK_FREQ`=48, `BAUD`=12 (`CLKS_PER_BIT`=4) unless noted.
- Reset mid-frame: start sending 0x55, assert `rst` during bit 3 → `tx`=1, `busy`=0 and `tx_ready`=1 immediately. No further frame appears, and the next push of 0x01 transmits normally.
- Single byte 0x55, 8N1 → `tx` is low from the edge after the push. The line carries 0 (start), then 1,0,1,0,1,0,1,0 LSB first, then 1 (stop). Each bit lasts 4 cycles, 40 cycles total, then `busy`=0.
- Burst of 5 bytes 0x00, 0xFF, 0xA5, 0x3C, 0x81 pushed with `tx_valid` held high → `tx_ready` drops after 4 bytes are queued and recovers as pops occur. All 5 frames are sent back-to-back with no idle cycles, in order, 200 cycles total.
- Parity: `PARITY`=1, byte 0x07 → parity bit 1; `PARITY`=2, byte 0x07 → parity bit 0. Frames are 44 cycles long.
- `STOP_BITS`=2, two bytes 0x0F, 0xF0 → a stop high of 8 cycles between frames, with the second start bit on the following cycle.
- Default parameters (12 MHz, 9600 baud), byte 0x41 → each bit period is 1250 cycles (104.17 µs at an 83.33 ns clock), and a UART receiver model decodes 0x41.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths:
// parity modes, FSM state encoding and baud divisor helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered occupancy and full/empty flags.
// The head entry is presented combinationally on rd_data.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd)
      count_nxt = count + 1'b1;
    else if (!do_wr && do_rd)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// Byte-oriented UART transmitter: FIFO-buffered bytes serialised LSB first
// with optional parity and one or two stop bits.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, waiting for a queued byte
// ST_START  | start bit (low)
// ST_DATA   | eight data bits, LSB first
// ST_PARITY | parity bit (only when parity is enabled)
// ST_STOP   | one or two stop bits (high), then next byte or idle
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUD       = 9600,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shift;
  logic          par_bit;

  logic [7:0]    fifo_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic          bit_end;
  logic          pop;
  logic          head_par;

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign head_par = (PARITY == PAR_ODD) ? ~^fifo_data : ^fifo_data;
  assign pop      = !fifo_empty &&
                    ((state == ST_IDLE) ||
                     (state == ST_STOP && bit_end && stop_idx == STOP_LAST));

  assign tx_ready = !fifo_full;
  assign busy     = (state != ST_IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // tx is registered, so each transition drives the level of the upcoming bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      baud_cnt <= (state == ST_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift   <= fifo_data;
            par_bit <= head_par;
            state   <= ST_START;
            tx      <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state    <= ST_STOP;
                stop_idx <= 1'b0;
                tx       <= 1'b1;
              end
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state    <= ST_STOP;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (stop_idx != STOP_LAST) begin
              stop_idx <= stop_idx + 1'b1;
            end else if (pop) begin
              shift   <= fifo_data;
              par_bit <= head_par;
              state   <= ST_START;
              tx      <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
